uart_core: RTL and testbench
============================

UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge system clock.
REQ-002 SHALL have port resetn, input, 1, reset, synchronous, active-low; clock clk.
REQ-003 SHALL have port ECHO, input, 1; when 1, each received byte is retransmitted.
REQ-004 SHALL have port UART_RX, input, 1, asynchronous serial input, idle high.
REQ-005 SHALL have port UART_TX, output, 1, serial output, idle high.
REQ-006 SHALL have port clockDividerValue, input, 20, clk cycles per bit; sampled at each frame start.
REQ-007 SHALL have port dataInTx, input, 8, byte to transmit.
REQ-008 SHALL have port dataInTxValid, input, 1, transmit request.
REQ-009 SHALL have port dataInTxBusy, output, 1, transmitter busy.
REQ-010 SHALL have port dataOutRx, output, 8, last received byte.
REQ-011 SHALL have port dataOutRxAvailable, output, 1, one-cycle strobe marking a new byte on dataOutRx.
REQ-012 SHALL have port rxError, output, 1, one-cycle framing-error strobe.
REQ-013 SHALL have port rxBitTick, output, 1, one-cycle strobe at each RX sample point.
REQ-014 SHALL have port txBitTick, output, 1, one-cycle strobe at each TX bit boundary.

Function
REQ-015 SHALL use frame format 8N1: start bit 0, 8 data bits LSB first, 1 stop bit 1; no parity.
REQ-016 SHALL make bit period N = clockDividerValue clk cycles; values 0..3 SHALL be treated as 4.
REQ-017 TX states SHALL be IDLE, START, DATA(0..7), STOP, returning to IDLE.
REQ-018 SHALL accept a transmit request when dataInTxValid=1 and dataInTxBusy=0 on the same rising edge; dataInTx is latched on that edge.
REQ-019 SHALL assert dataInTxBusy on the cycle after acceptance; it SHALL stay high until the stop bit has been driven for N cycles.
REQ-020 SHALL drop busy on the cycle after the stop bit completes; a new request on that cycle SHALL be accepted, allowing back-to-back frames with no idle gap beyond 1 cycle.
REQ-021 SHALL ignore dataInTxValid while busy; the request SHALL NOT be queued.
REQ-022 SHALL drive UART_TX low starting the cycle after acceptance; each bit SHALL last exactly N cycles; txBitTick SHALL pulse on the first cycle of each of the 10 bits.
REQ-023 SHALL pass UART_RX through a 2-flip-flop synchronizer before use.
REQ-024 RX states SHALL be IDLE, START, DATA(0..7), STOP.
REQ-025 RX SHALL enter START on a synchronized falling edge; it SHALL sample at N/2 (integer divide); if the line is high then, it SHALL return to IDLE silently (glitch rejection).
REQ-026 SHALL sample each subsequent bit N cycles after the previous sample; rxBitTick SHALL pulse on every sample, start bit included.
REQ-027 If the stop sample is 1, SHALL update dataOutRx and pulse dataOutRxAvailable for 1 cycle on the same edge.
REQ-028 If the stop sample is 0, SHALL pulse rxError for 1 cycle, leave dataOutRx unchanged, and wait for the line to go high before re-arming.
REQ-029 dataOutRx SHALL hold its value until the next good frame.
REQ-030 With ECHO=1 and the transmitter idle, a received byte SHALL be loaded into TX on the dataOutRxAvailable cycle.
REQ-031 With ECHO=1, if the transmitter is busy, or an external dataInTxValid occurs in the same cycle, the external request SHALL win and the echo byte SHALL be dropped.
REQ-032 TX and RX SHALL operate independently and full duplex.

Reset
REQ-033 While resetn=0 at a clk edge, SHALL set UART_TX=1, dataInTxBusy=0, dataOutRx=0x00, and dataOutRxAvailable, rxError, rxBitTick and txBitTick all 0; both FSMs SHALL go to IDLE and all counters SHALL clear.
REQ-034 Reset asserted mid-frame SHALL abort the frame immediately: UART_TX=1 next edge, with no partial byte or error reported.

Verification
REQ-035 Div=131, send 0x68 ('h') -> UART_TX low for 131 cycles, then bits 0,0,0,1,0,1,1,0 at 131 cycles each, then high; busy high exactly 1310 cycles.
REQ-036 Loop UART_TX to UART_RX and send 0x07, then 14 bytes "he\x07llo, world!" using the valid/busy handshake -> each byte appears on dataOutRx with a single available strobe, in order, and no rxError.
REQ-037 RX frame 0x55 with stop bit driven 0 -> one rxError pulse, no available strobe, dataOutRx unchanged.
REQ-038 RX low glitch shorter than N/2 cycles -> no rxBitTick after the first, no strobes, RX back to IDLE.
REQ-039 ECHO=1, receive 0x41 -> UART_TX emits 0x41 frame starting the cycle after the available strobe.
REQ-040 resetn=0 during DATA bit 3 of TX -> UART_TX=1 and busy=0 the next edge; a new request after release transmits a full correct frame.

Source files
------------

// File: rtl/uart_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// uart_core: full-duplex 8N1 UART with per-frame divider and optional echo.
// Revision: 1.0
// ============================================================================
module uart_core (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ECHO,
  input  logic        UART_RX,
  output logic        UART_TX,
  input  logic [19:0] clockDividerValue,
  input  logic [7:0]  dataInTx,
  input  logic        dataInTxValid,
  output logic        dataInTxBusy,
  output logic [7:0]  dataOutRx,
  output logic        dataOutRxAvailable,
  output logic        rxError,
  output logic        rxBitTick,
  output logic        txBitTick
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [19:0] div_eff;
  assign div_eff = (clockDividerValue < 20'd4) ? 20'd4 : clockDividerValue;

  logic [1:0]  tx_state;
  logic [19:0] tx_div;
  logic [19:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_req;
  logic [7:0]  tx_byte;
  logic        tx_bit_end;

  // An external request always takes priority over the echoed byte.
  assign tx_req     = dataInTxValid || (ECHO && dataOutRxAvailable);
  assign tx_byte    = dataInTxValid ? dataInTx : dataOutRx;
  assign tx_bit_end = (tx_cnt == tx_div - 20'd1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_state     <= S_IDLE;
      tx_div       <= 20'd0;
      tx_cnt       <= 20'd0;
      tx_bit       <= 3'd0;
      tx_shift     <= 8'd0;
      UART_TX      <= 1'b1;
      dataInTxBusy <= 1'b0;
      txBitTick    <= 1'b0;
    end else begin
      txBitTick <= 1'b0;
      if (tx_state == S_IDLE) begin
        if (tx_req && !dataInTxBusy) begin
          tx_state     <= S_START;
          tx_div       <= div_eff;
          tx_cnt       <= 20'd0;
          tx_shift     <= tx_byte;
          dataInTxBusy <= 1'b1;
          UART_TX      <= 1'b0;
          txBitTick    <= 1'b1;
        end
      end else if (!tx_bit_end) begin
        tx_cnt <= tx_cnt + 20'd1;
      end else begin
        tx_cnt <= 20'd0;
        if (tx_state == S_STOP) begin
          tx_state     <= S_IDLE;
          dataInTxBusy <= 1'b0;
        end else if (tx_state == S_DATA && tx_bit == 3'd7) begin
          tx_state  <= S_STOP;
          UART_TX   <= 1'b1;
          txBitTick <= 1'b1;
        end else begin
          tx_state  <= S_DATA;
          tx_bit    <= (tx_state == S_START) ? 3'd0 : tx_bit + 3'd1;
          UART_TX   <= tx_shift[0];
          tx_shift  <= {1'b0, tx_shift[7:1]};
          txBitTick <= 1'b1;
        end
      end
    end
  end

  logic        rx_s1;
  logic        rx_s2;
  logic        rx_prev;
  logic [1:0]  rx_state;
  logic [19:0] rx_div;
  logic [19:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_sample;

  // Start bit is sampled half a bit in; every later bit a full bit after that.
  assign rx_sample = (rx_state == S_START) ? (rx_cnt == (rx_div >> 1) - 20'd1)
                                           : (rx_cnt == rx_div - 20'd1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_s1              <= 1'b1;
      rx_s2              <= 1'b1;
      rx_prev            <= 1'b1;
      rx_state           <= S_IDLE;
      rx_div             <= 20'd0;
      rx_cnt             <= 20'd0;
      rx_bit             <= 3'd0;
      rx_shift           <= 8'd0;
      dataOutRx          <= 8'd0;
      dataOutRxAvailable <= 1'b0;
      rxError            <= 1'b0;
      rxBitTick          <= 1'b0;
    end else begin
      rx_s1              <= UART_RX;
      rx_s2              <= rx_s1;
      rx_prev            <= rx_s2;
      dataOutRxAvailable <= 1'b0;
      rxError            <= 1'b0;
      rxBitTick          <= 1'b0;
      // After a framing error the line must return high before a new falling edge.
      if (rx_state == S_IDLE) begin
        if (rx_prev && !rx_s2) begin
          rx_state <= S_START;
          rx_div   <= div_eff;
          rx_cnt   <= 20'd0;
        end
      end else if (!rx_sample) begin
        rx_cnt <= rx_cnt + 20'd1;
      end else begin
        rx_cnt    <= 20'd0;
        rxBitTick <= 1'b1;
        case (rx_state)
          S_START: begin
            if (rx_s2) begin
              rx_state <= S_IDLE;
            end else begin
              rx_state <= S_DATA;
              rx_bit   <= 3'd0;
            end
          end
          S_DATA: begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end
          default: begin
            rx_state <= S_IDLE;
            if (rx_s2) begin
              dataOutRx          <= rx_shift;
              dataOutRxAvailable <= 1'b1;
            end else begin
              rxError <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_core.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for uart_core: TX waveform, loopback scoreboard, RX errors, echo, reset.
module tb_uart_core;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ECHO = 1'b0;
  logic        rx_drv = 1'b1;
  logic        loop = 1'b0;
  logic        UART_RX;
  logic        UART_TX;
  logic [19:0] div = 20'd16;
  logic [7:0]  din = 8'd0;
  logic        din_valid = 1'b0;
  logic        busy;
  logic [7:0]  dout;
  logic        avail;
  logic        rx_err;
  logic        rx_tick;
  logic        tx_tick;

  int checks = 0;
  int errors = 0;
  int avail_cnt = 0;
  int err_cnt = 0;
  int rtick_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  assign UART_RX = loop ? UART_TX : rx_drv;

  uart_core dut (
    .clk(clk), .resetn(resetn), .ECHO(ECHO), .UART_RX(UART_RX), .UART_TX(UART_TX),
    .clockDividerValue(div), .dataInTx(din), .dataInTxValid(din_valid),
    .dataInTxBusy(busy), .dataOutRx(dout), .dataOutRxAvailable(avail),
    .rxError(rx_err), .rxBitTick(rx_tick), .txBitTick(tx_tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every received byte is compared against the oldest pending expectation.
  always @(negedge clk) begin
    if (avail === 1'b1) begin
      avail_cnt++;
      if (exp_q.size() == 0) check("rx_unexpected", 32'(dout), 32'h100);
      else                   check("rx_byte", 32'(dout), 32'(exp_q.pop_front()));
    end
    if (rx_err === 1'b1)  err_cnt++;
    if (rx_tick === 1'b1) rtick_cnt++;
  end

  task automatic send_start(input logic [7:0] b, input string tag);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) check({tag, "_busy_timeout"}, 32'(busy), 32'd0);
    din = b;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  // Called on the first negedge after acceptance.
  task automatic tx_frame_check(input logic [7:0] b, input int n, input string tag);
    int busy_cnt;
    int tick_bad;
    int bad;
    logic expb;
    busy_cnt = 0;
    tick_bad = 0;
    for (int k = 0; k < 10; k++) begin
      expb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      bad = 0;
      for (int c = 0; c < n; c++) begin
        if (!(k == 0 && c == 0)) @(negedge clk);
        if (UART_TX !== expb) bad++;
        if (tx_tick !== (c == 0)) tick_bad++;
        if (busy === 1'b1) busy_cnt++;
      end
      check($sformatf("%s_bit%0d_bad_cycles", tag, k), 32'(bad), 32'd0);
    end
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(10 * n));
    check({tag, "_tick_bad"}, 32'(tick_bad), 32'd0);
    @(negedge clk);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_tx_idle_after"}, 32'(UART_TX), 32'd1);
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stopv, input int n);
    rx_drv = 1'b0;
    repeat (n) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (n) @(negedge clk);
    end
    rx_drv = stopv;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] msg [15];
    int a0, e0, t0, t;
    msg = '{8'h07, 8'h68, 8'h65, 8'h07, 8'h6c, 8'h6c, 8'h6f, 8'h2c,
            8'h20, 8'h77, 8'h6f, 8'h72, 8'h6c, 8'h64, 8'h21};

    repeat (3) @(negedge clk);
    check("rst_tx", 32'(UART_TX), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_avail", 32'(avail), 32'd0);
    check("rst_rxerr", 32'(rx_err), 32'd0);
    check("rst_rxtick", 32'(rx_tick), 32'd0);
    check("rst_txtick", 32'(tx_tick), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    div = 20'd131;
    send_start(8'h68, "tx68");
    tx_frame_check(8'h68, 131, "tx68");

    div = 20'd16;
    loop = 1'b1;
    repeat (2) @(negedge clk);
    a0 = avail_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back(msg[i]);
      send_start(msg[i], "loop");
    end
    repeat (12 * 16) @(negedge clk);
    check("loop_count", 32'(avail_cnt - a0), 32'd15);
    check("loop_rxerr", 32'(err_cnt - e0), 32'd0);
    check("loop_pending", 32'(exp_q.size()), 32'd0);
    loop = 1'b0;
    @(negedge clk);

    a0 = avail_cnt;
    e0 = err_cnt;
    rx_send(8'h55, 1'b0, 16);
    repeat (16) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("ferr_pulses", 32'(err_cnt - e0), 32'd1);
    check("ferr_avail", 32'(avail_cnt - a0), 32'd0);
    check("ferr_dout_held", 32'(dout), 32'h21);

    a0 = avail_cnt;
    e0 = err_cnt;
    t0 = rtick_cnt;
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_ticks", 32'(rtick_cnt - t0), 32'd1);
    check("glitch_avail", 32'(avail_cnt - a0), 32'd0);
    check("glitch_rxerr", 32'(err_cnt - e0), 32'd0);
    exp_q.push_back(8'h3C);
    rx_send(8'h3C, 1'b1, 16);
    repeat (32) @(negedge clk);
    check("post_glitch_avail", 32'(avail_cnt - a0), 32'd1);
    check("post_glitch_pending", 32'(exp_q.size()), 32'd0);

    ECHO = 1'b1;
    exp_q.push_back(8'h41);
    rx_send(8'h41, 1'b1, 16);
    t = 0;
    while (avail !== 1'b1 && t < 64) begin
      @(negedge clk);
      t++;
    end
    check("echo_avail_seen", 32'(avail), 32'd1);
    @(negedge clk);
    tx_frame_check(8'h41, 16, "echo");
    ECHO = 1'b0;

    send_start(8'hA5, "rst");
    repeat (4 * 16 + 2) @(negedge clk);
    check("rst_mid_bit3", 32'(UART_TX), 32'd0);
    resetn = 1'b0;
    @(negedge clk);
    check("rst_mid_tx", 32'(UART_TX), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_txtick", 32'(tx_tick), 32'd0);
    check("rst_mid_dout", 32'(dout), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    send_start(8'h5A, "post");
    tx_frame_check(8'h5A, 16, "post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
